ram_bus_loader: RTL and testbench

//  Bus master that sits upstream of the data RAM. It accepts a byte stream over a

---
 rtl/ram_bus_loader_if.sv | 27 ++
 rtl/ram_bus_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_bus_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_loader_if.sv
// Control and byte-stream handshake bundle for ram_bus_loader.
// The loader side uses the master modport; the surrounding system
// (UART receiver, start logic, bus arbiter) uses the slave modport.
interface ram_bus_loader_if;
    logic       START;
    logic [7:0] BASE_ADDR;
    logic [7:0] LENGTH;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic       BUS_REQ;
    logic       BUS_GNT;
    logic       BUSY;
    logic       DONE;
    logic       CHK_OK;
    logic       CHK_ERR;

    modport master (
        input  START, BASE_ADDR, LENGTH, RX_DATA, RX_VALID, BUS_GNT,
        output RX_READY, BUS_REQ, BUSY, DONE, CHK_OK, CHK_ERR
    );

    modport slave (
        output START, BASE_ADDR, LENGTH, RX_DATA, RX_VALID, BUS_GNT,
        input  RX_READY, BUS_REQ, BUSY, DONE, CHK_OK, CHK_ERR
    );
endinterface

// File: rtl/ram_bus_loader.sv
// Bus master that streams bytes from a valid/ready source into consecutive
// RAM addresses over the shared tristate bus, then optionally reads the
// block back and compares 8-bit sums. Bus ownership via BUS_REQ/BUS_GNT.
// The tristate bus pins stay plain nets on the module boundary so they
// resolve with the RAM and processor drivers; control lives in the interface.
module ram_bus_loader #(
    parameter int unsigned VERIFY     = 1,
    parameter int unsigned RAM_RD_LAT = 1   // must be >= 1
) (
    input  logic             CLK,
    input  logic             RESET,
    ram_bus_loader_if.master bif,
    output wire  [7:0]       BUS_ADDR,
    inout  wire  [7:0]       BUS_DATA,
    output wire              BUS_WE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BYTE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_CAP,
        S_RELEASE,
        S_FINISH
    } state_t;

    localparam int unsigned LAT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

    state_t           state_q, state_d;
    logic [7:0]       ptr_q, ptr_d;
    logic [7:0]       base_q, base_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       wsum_q, wsum_d;
    logic [7:0]       rsum_q, rsum_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             lost_q, lost_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             own_q, own_d;
    logic             we_q, we_d;
    logic             rdy_q, rdy_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             drive;
    logic             rx_fire;

    // Drive enables are registered, then gated by the live grant so a
    // revoked grant takes the bus off immediately.
    assign drive    = own_q & bif.BUS_GNT;
    assign rx_fire  = bif.RX_VALID & rdy_q & bif.BUS_GNT;

    assign BUS_ADDR = drive ? ptr_q : 8'bz;
    assign BUS_WE   = drive ? we_q  : 1'bz;
    assign BUS_DATA = (drive & we_q) ? byte_q : 8'bz;

    assign bif.RX_READY = rdy_q & bif.BUS_GNT;
    assign bif.BUS_REQ  = req_q;
    assign bif.BUSY     = busy_q;
    assign bif.DONE     = done_q;
    assign bif.CHK_OK   = ok_q;
    assign bif.CHK_ERR  = err_q;

    // Next-state, datapath updates and registered output enables.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        lat_d   = lat_q;
        lost_d  = lost_q;
        ok_d    = ok_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bif.START) begin
                    ok_d   = 1'b0;
                    err_d  = 1'b0;
                    lost_d = 1'b0;
                    if (bif.LENGTH == '0) begin
                        state_d = S_FINISH;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        ptr_d   = bif.BASE_ADDR;
                        base_d  = bif.BASE_ADDR;
                        len_d   = bif.LENGTH;
                        cnt_d   = bif.LENGTH;
                        wsum_d  = '0;
                        rsum_d  = '0;
                    end
                end
            end
            S_REQ: begin
                if (bif.BUS_GNT) state_d = S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
                if (!bif.BUS_GNT) begin
                    lost_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (rx_fire) begin
                    byte_d  = bif.RX_DATA;
                    wsum_d  = wsum_q + bif.RX_DATA;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bif.BUS_GNT) begin
                    lost_d  = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    ptr_d = ptr_q + 8'd1;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        if (VERIFY != 0) begin
                            state_d = S_RD_ADDR;
                            ptr_d   = base_q;
                            cnt_d   = len_q;
                            lat_d   = '0;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        state_d = S_WAIT_BYTE;
                    end
                end
            end
            S_RD_ADDR: begin
                if (!bif.BUS_GNT) begin
                    lost_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (lat_q == LAT_W'(RAM_RD_LAT - 1)) begin
                    state_d = S_RD_CAP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_RD_CAP: begin
                if (!bif.BUS_GNT) begin
                    lost_d  = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    rsum_d  = rsum_q + BUS_DATA;
                    ptr_d   = ptr_q + 8'd1;
                    cnt_d   = cnt_q - 8'd1;
                    lat_d   = '0;
                    state_d = (cnt_q == 8'd1) ? S_RELEASE : S_RD_ADDR;
                end
            end
            S_RELEASE: begin
                state_d = S_FINISH;
                ok_d    = !lost_q && ((VERIFY == 0) || (rsum_q == wsum_q));
                err_d   = !ok_d;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flags are decoded from the next state so they are glitch-free
    // registers aligned with the state they belong to.
    always_comb begin
        own_d  = state_d inside {S_WAIT_BYTE, S_WRITE, S_RD_ADDR, S_RD_CAP};
        we_d   = (state_d == S_WRITE);
        rdy_d  = (state_d == S_WAIT_BYTE);
        req_d  = state_d inside {S_REQ, S_WAIT_BYTE, S_WRITE, S_RD_ADDR, S_RD_CAP};
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State and datapath registers; synchronous reset aborts any load.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            lat_q   <= '0;
            lost_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            lat_q   <= lat_d;
            lost_q  <= lost_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            own_q   <= own_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_bus_loader.sv
// Bench for ram_bus_loader: a behavioural RAM on the tristate bus plus a
// transaction-level expectation (which bytes land where, and whether the
// read-back sum can match) for directed and randomized loads.
module tb_ram_bus_loader;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_bus_loader_if bif ();
    wire [7:0] bus_addr;
    wire [7:0] bus_data;
    wire       bus_we;

    ram_bus_loader #(.VERIFY(1), .RAM_RD_LAT(LAT)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .bif      (bif),
        .BUS_ADDR (bus_addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (bus_we)
    );

    // Behavioural RAM: registered read with LAT cycles of latency.
    logic [7:0]  mem      [0:255];
    logic [7:0]  rd_pipe  [0:LAT-1];
    logic [7:0]  log_addr [0:1023];
    logic [7:0]  log_data [0:1023];
    int unsigned wr_total = 0;
    bit          corrupt_arm = 1'b0;
    int unsigned corrupt_at = 0;
    logic [7:0]  corrupt_addr = 8'h00;

    assign bus_data = (bus_we !== 1'b1) ? rd_pipe[LAT-1] : 8'bz;

    // RAM write capture, write log, optional corruption after the last write.
    always @(posedge clk) begin
        if (bus_we === 1'b1) begin
            mem[bus_addr]             <= bus_data;
            log_addr[wr_total % 1024] <= bus_addr;
            log_data[wr_total % 1024] <= bus_data;
            wr_total                  <= wr_total + 1;
            if (corrupt_arm && (wr_total + 1 == corrupt_at))
                mem[corrupt_addr] <= mem[corrupt_addr] ^ 8'hFF;
        end
        rd_pipe[0] <= mem[bus_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, bif.RX_READY, 0);
        chk({tag, "_bus_req"},  bif.BUS_REQ, 0);
        chk({tag, "_busy"},     bif.BUSY, 0);
        chk({tag, "_done"},     bif.DONE, 0);
        chk({tag, "_chk_ok"},   bif.CHK_OK, 0);
        chk({tag, "_chk_err"},  bif.CHK_ERR, 0);
        chk({tag, "_bus_we"},   bus_we === 1'b1, 0);
    endtask

    // One load: base, len, gapped RX_VALID, grant delay, drop grant after N
    // writes (0 = never), corrupt first cell, reset during read-back, 01.. bytes.
    task automatic run_load(input logic [7:0] base, input int unsigned len,
                            input bit gapped, input int unsigned gnt_dly,
                            input int unsigned drop_after, input bit corrupt,
                            input bit rst_mid, input bit seq_bytes);
        logic [7:0]  bytes [$];
        logic [7:0]  a;
        logic [7:0]  exp_byte;
        int unsigned w0, idx, cyc, req_cnt, nwr, done_cyc, exp_n;
        bit          done_seen, req_seen, dropped, hit_rst, late_done, exp_ok;
        logic        ok_at_done, err_at_done;

        for (int i = 0; i < len; i++)
            bytes.push_back(seq_bytes ? 8'(i + 1) : 8'($urandom));
        exp_n  = (drop_after != 0 && drop_after < len) ? drop_after : len;
        exp_ok = (exp_n == len) && !corrupt;

        w0 = wr_total; idx = 0; cyc = 0; req_cnt = 0; done_cyc = 0;
        done_seen = 0; req_seen = 0; dropped = 0; hit_rst = 0;
        ok_at_done = 1'b0; err_at_done = 1'b0;
        corrupt_addr = base;
        corrupt_at   = w0 + len;
        corrupt_arm  = corrupt;

        @(negedge clk);
        bif.START     = 1'b1;
        bif.BASE_ADDR = base;
        bif.LENGTH    = 8'(len);
        @(negedge clk);
        bif.START     = 1'b0;
        bif.BASE_ADDR = 8'($urandom);
        bif.LENGTH    = 8'($urandom);
        chk("busy_after_start", bif.BUSY, 1);

        while (!done_seen && cyc < 3000) begin
            cyc++;
            if (bif.BUS_REQ === 1'b1) begin
                req_seen = 1;
                req_cnt++;
            end
            if (bif.DONE === 1'b1) begin
                done_seen   = 1;
                done_cyc    = cyc;
                ok_at_done  = bif.CHK_OK;
                err_at_done = bif.CHK_ERR;
            end
            if (rst_mid && (wr_total - w0) == len) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                hit_rst = 1;
                break;
            end
            if (bif.BUS_REQ !== 1'b1) bif.BUS_GNT = 1'b0;
            else if (!dropped && req_cnt > gnt_dly) bif.BUS_GNT = 1'b1;
            if (drop_after != 0 && !dropped && (wr_total - w0) == drop_after) begin
                bif.BUS_GNT = 1'b0;
                dropped = 1;
            end
            if (idx < len && (!gapped || (cyc % 3) == 0)) begin
                bif.RX_VALID = 1'b1;
                bif.RX_DATA  = bytes[idx];
            end else begin
                bif.RX_VALID = 1'b0;
                bif.RX_DATA  = 8'($urandom);
            end
            #1;
            if (bif.BUS_GNT == 1'b0) chk("no_we_without_gnt", bus_we === 1'b1, 0);
            if (bif.RX_VALID && bif.RX_READY === 1'b1) idx++;
            @(negedge clk);
        end
        bif.RX_VALID = 1'b0;

        if (rst_mid) begin
            chk("reset_reached", hit_rst, 1);
            bif.BUS_GNT = 1'b0;
            chk_reset_outputs("mid_reset");
            late_done = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bif.DONE === 1'b1) late_done = 1;
            end
            chk("mid_reset_no_done", late_done, 0);
            return;
        end

        chk("done_seen", done_seen, 1);
        chk("chk_ok_at_done", ok_at_done, exp_ok);
        chk("chk_err_at_done", err_at_done, !exp_ok);
        nwr = wr_total - w0;
        chk("write_count", nwr, exp_n);
        chk("writes_eq_accepted", nwr, idx);
        for (int i = 0; i < exp_n && i < nwr; i++) begin
            a = base + 8'(i);
            exp_byte = (corrupt && i == 0) ? (bytes[0] ^ 8'hFF) : bytes[i];
            chk("wr_addr", log_addr[(w0 + i) % 1024], a);
            chk("wr_data", log_data[(w0 + i) % 1024], bytes[i]);
            chk("mem_content", mem[a], exp_byte);
        end
        if (len == 0) begin
            chk("len0_no_req", req_seen, 0);
            chk("len0_done_fast", done_cyc <= 2, 1);
        end
        chk("busy_after_done", bif.BUSY, 0);
        chk("done_one_cycle", bif.DONE, 0);
        chk("req_after_done", bif.BUS_REQ, 0);
        chk("bus_released", bus_we === 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("chk_ok_held", bif.CHK_OK, exp_ok);
        chk("chk_err_held", bif.CHK_ERR, !exp_ok);
    endtask

    initial begin
        rst           = 1'b1;
        bif.START     = 1'b0;
        bif.BASE_ADDR = 8'h00;
        bif.LENGTH    = 8'h00;
        bif.RX_DATA   = 8'h00;
        bif.RX_VALID  = 1'b0;
        bif.BUS_GNT   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // base, len, gapped, gnt_dly, drop_after, corrupt, rst_mid, seq_bytes
        run_load(8'h10, 4, 0, 2, 0, 0, 0, 1);
        run_load(8'h10, 4, 1, 2, 0, 0, 0, 0);
        run_load(8'hFE, 3, 0, 1, 0, 0, 0, 0);
        run_load(8'h20, 5, 0, 0, 0, 1, 0, 0);
        run_load(8'h30, 6, 0, 1, 2, 0, 0, 0);
        run_load(8'h00, 0, 0, 0, 0, 0, 0, 0);
        run_load(8'h40, 8, 0, 0, 0, 0, 1, 0);
        for (int t = 0; t < 6; t++)
            run_load(8'($urandom), $urandom_range(1, 12), 1'($urandom),
                     $urandom_range(0, 3), 0, 0, 0, 0);
        run_load(8'($urandom), 7, 1, 1, $urandom_range(1, 6), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
